// File: rtl/readback_framer_pkg.sv
// rtl/readback_framer_pkg.sv - shared types, header layout and helpers for the readback framer
package readback_framer_pkg;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 8;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header word layout: {magic, tag, seq, len}
    localparam int HDR_LEN_LSB   = 0;
    localparam int HDR_SEQ_LSB   = 8;
    localparam int HDR_TAG_LSB   = 16;
    localparam int HDR_MAGIC_LSB = 24;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HEADER,
        PAYLOAD,
        TRAILER
    } state_t;

    function automatic logic [WORD_W-1:0] make_header(
        input logic [7:0]       tag,
        input logic [7:0]       seq,
        input logic [LEN_W-1:0] len
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        w[HDR_TAG_LSB   +: 8] = tag;
        w[HDR_SEQ_LSB   +: 8] = seq;
        w[HDR_LEN_LSB   +: 8] = len;
        return w;
    endfunction

endpackage

// File: rtl/readback_framer_if.sv
// rtl/readback_framer_if.sv - record producer and FIFO write-side signals of the framer
interface readback_framer_if;
    import readback_framer_pkg::*;

    logic              rec_start;
    logic [7:0]        rec_tag;
    logic              rec_valid;
    logic [WORD_W-1:0] rec_data;
    logic              rec_last;
    logic              rec_ready;
    logic              fifo_full;
    logic              fifo_write;
    logic [WORD_W-1:0] fifo_data;

    // master: the environment around the framer (control_unit plus FIFO)
    modport master (
        output rec_start, rec_tag, rec_valid, rec_data, rec_last, fifo_full,
        input  rec_ready, fifo_write, fifo_data
    );

    modport slave (
        input  rec_start, rec_tag, rec_valid, rec_data, rec_last, fifo_full,
        output rec_ready, fifo_write, fifo_data
    );

endinterface

// File: rtl/framer_record_buffer.sv
// rtl/framer_record_buffer.sv - 1W/1R record RAM with synchronous read and read-address prefetch
module framer_record_buffer #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_restart,
    input  logic              rd_next,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MAX_WORDS];
    logic [ADDR_W-1:0] rd_addr;

    // Read the address the pointer is about to hold, so rd_data always
    // matches rd_ptr one cycle later without a bubble.
    always_comb begin
        rd_addr = rd_ptr;
        if (rd_restart) begin
            rd_addr = '0;
        end else if (rd_next) begin
            rd_addr = rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else begin
            rd_ptr <= rd_addr;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/readback_framer.sv
// rtl/readback_framer.sv - frames variable-length readback records as header/payload/checksum into the readback FIFO
module readback_framer
    import readback_framer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic             sys_clk,
    input  logic             reset,
    readback_framer_if.slave rec,
    output logic             busy,
    output logic [7:0]       seq_num,
    output logic             err_overflow,
    output logic             err_abort
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_t            state;
    logic [7:0]        tag;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] chk;

    logic              emit;
    logic              fifo_wr;
    logic              accept;
    logic              overflow_hit;
    logic              last_payload;
    logic [LEN_W-1:0]  base_len;
    logic [DATA_W-1:0] base_chk;
    logic [DATA_W-1:0] hdr_word;
    logic [DATA_W-1:0] buf_rd_data;
    logic [ADDR_W-1:0] buf_rd_ptr;
    logic [DATA_W-1:0] frame_word;

    assign emit     = (state == HEADER) || (state == PAYLOAD) || (state == TRAILER);
    assign fifo_wr  = emit && !rec.fifo_full;
    assign accept   = rec.rec_valid && (state == COLLECT);

    // A start in the same cycle as a word makes that word the first of the new record.
    assign base_len = rec.rec_start ? '0 : len;
    assign base_chk = rec.rec_start ? '0 : chk;

    // A full buffer cannot take another word, so even a final word beyond MAX_WORDS drops the record.
    assign overflow_hit = accept && (base_len == MAX_LEN);
    assign last_payload = (LEN_W'(buf_rd_ptr) == (len - 1'b1));
    assign hdr_word     = make_header(tag, seq_num, len);

    assign rec.rec_ready  = (state == COLLECT);
    assign rec.fifo_write = fifo_wr;
    assign rec.fifo_data  = frame_word;
    assign busy           = (state != IDLE);

    always_comb begin
        frame_word = '0;
        case (state)
            HEADER:  frame_word = hdr_word;
            PAYLOAD: frame_word = buf_rd_data;
            TRAILER: frame_word = chk ^ hdr_word;
            default: frame_word = '0;
        endcase
    end

    framer_record_buffer #(
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_record_buffer (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .wr_en      (accept && !overflow_hit),
        .wr_addr    (base_len[ADDR_W-1:0]),
        .wr_data    (rec.rec_data),
        .rd_restart (state == HEADER),
        .rd_next    (fifo_wr && (state == PAYLOAD)),
        .rd_ptr     (buf_rd_ptr),
        .rd_data    (buf_rd_data)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= IDLE;
            tag          <= '0;
            len          <= '0;
            chk          <= '0;
            seq_num      <= '0;
            err_overflow <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rec.rec_start) begin
                        tag   <= rec.rec_tag;
                        len   <= '0;
                        chk   <= '0;
                        state <= COLLECT;
                    end else if (rec.rec_valid) begin
                        err_abort <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (rec.rec_start) begin
                        err_abort <= 1'b1;
                        tag       <= rec.rec_tag;
                    end
                    if (overflow_hit) begin
                        err_overflow <= 1'b1;
                        state        <= IDLE;
                    end else if (accept) begin
                        len <= base_len + 1'b1;
                        chk <= base_chk ^ rec.rec_data;
                        if (rec.rec_last) begin
                            state <= HEADER;
                        end
                    end else begin
                        len <= base_len;
                        chk <= base_chk;
                    end
                end
                HEADER: begin
                    if (rec.rec_start) err_abort <= 1'b1;
                    if (fifo_wr) state <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (rec.rec_start) err_abort <= 1'b1;
                    if (fifo_wr && last_payload) state <= TRAILER;
                end
                TRAILER: begin
                    if (rec.rec_start) err_abort <= 1'b1;
                    if (fifo_wr) begin
                        seq_num <= seq_num + 8'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readback_framer.sv
// tb/tb_readback_framer.sv - self-checking bench for readback_framer
module tb_readback_framer;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       busy;
    logic [7:0] seq_num;
    logic       err_overflow;
    logic       err_abort;

    always #5 sys_clk = ~sys_clk;

    readback_framer_if bus();

    readback_framer #(
        .DATA_W    (32),
        .MAX_WORDS (64),
        .ADDR_W    (6)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .rec          (bus.slave),
        .busy         (busy),
        .seq_num      (seq_num),
        .err_overflow (err_overflow),
        .err_abort    (err_abort)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frame_wr = 0;
    int          wr_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  exp_seq = 8'd0;

    typedef struct {
        bit              do_reset;
        logic [7:0]      tag;
        int              n;
        logic [0:3][31:0] w;
        int              stall_at;
        int              stall_len;
        logic [31:0]     hdr;
        logic [31:0]     trl;
        logic [7:0]      seq_after;
    } vec_t;

    vec_t tbl[4];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Scoreboard: every FIFO write is popped against the expected stream.
    always @(negedge sys_clk) begin
        cyc++;
        if (!reset) begin
            if (bus.fifo_full) chk32("no_write_when_full", {31'd0, bus.fifo_write}, 32'd0);
            if (bus.fifo_write) begin
                frame_wr++;
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none", bus.fifo_data);
                end else begin
                    chk32("fifo_data", bus.fifo_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.fifo_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_seq = 8'd0;
    endtask

    task automatic start_rec(input logic [7:0] tag);
        bus.rec_start = 1'b1;
        bus.rec_tag   = tag;
        tick();
        bus.rec_start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            int b;
            b = 0;
            bus.rec_valid = 1'b1;
            bus.rec_data  = words_q[i];
            bus.rec_last  = last_on_final && (i == n - 1);
            while (!bus.rec_ready && b < 50) begin
                tick();
                b++;
            end
            if (b == 50) chk32("accept_timeout", 32'(b), 32'd0);
            tick();
        end
        bus.rec_valid = 1'b0;
        bus.rec_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (busy && b < 300) begin
            tick();
            b++;
        end
        if (b == 300) chk32("idle_timeout", 32'(b), 32'd0);
    endtask

    task automatic push_model(input logic [7:0] tag, input int n);
        logic [31:0] hdr;
        logic [31:0] c;
        hdr = {8'hA5, tag, exp_seq, 8'(n)};
        c = 32'd0;
        exp_q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(words_q[i]);
            c = c ^ words_q[i];
        end
        exp_q.push_back(c ^ hdr);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rec_start = 1'b0;
        bus.rec_tag   = 8'd0;
        bus.rec_valid = 1'b0;
        bus.rec_data  = 32'd0;
        bus.rec_last  = 1'b0;
        bus.fifo_full = 1'b0;

        tbl[0] = '{1'b1, 8'h12, 3, {32'h1, 32'h2, 32'h4, 32'h0}, -1, 0,
                   32'hA5120003, 32'hA5120004, 8'd1};
        tbl[1] = '{1'b0, 8'h12, 3, {32'h1, 32'h2, 32'h4, 32'h0}, 2, 10,
                   32'hA5120103, 32'hA5120104, 8'd2};
        tbl[2] = '{1'b0, 8'h7E, 4, {32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888}, -1, 0,
                   32'hA57E0204, 32'h5A81FDFB, 8'd3};
        tbl[3] = '{1'b0, 8'h00, 1, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 3,
                   32'hA5000301, 32'hA5000301, 8'd4};

        // Reset state
        do_reset();
        chk32("rst_rec_ready", {31'd0, bus.rec_ready}, 32'd0);
        chk32("rst_fifo_write", {31'd0, bus.fifo_write}, 32'd0);
        chk32("rst_fifo_data", bus.fifo_data, 32'd0);
        chk32("rst_busy", {31'd0, busy}, 32'd0);
        chk32("rst_seq", {24'd0, seq_num}, 32'd0);
        chk32("rst_err_overflow", {31'd0, err_overflow}, 32'd0);
        chk32("rst_err_abort", {31'd0, err_abort}, 32'd0);

        // Table-driven frames, with and without FIFO back-pressure
        for (int t = 0; t < 4; t++) begin
            if (tbl[t].do_reset) do_reset();
            words_q.delete();
            for (int i = 0; i < tbl[t].n; i++) words_q.push_back(tbl[t].w[i]);
            frame_wr = 0;
            wr_cyc.delete();
            exp_q.push_back(tbl[t].hdr);
            for (int i = 0; i < tbl[t].n; i++) exp_q.push_back(tbl[t].w[i]);
            exp_q.push_back(tbl[t].trl);
            start_rec(tbl[t].tag);
            send_words(tbl[t].n, 1'b1);
            if (tbl[t].stall_at >= 0) begin
                int b;
                b = 0;
                while (frame_wr < tbl[t].stall_at && b < 50) begin
                    tick();
                    b++;
                end
                if (b == 50) chk32("stall_timeout", 32'(b), 32'd0);
                bus.fifo_full = 1'b1;
                repeat (tbl[t].stall_len) tick();
                bus.fifo_full = 1'b0;
            end
            wait_idle();
            chk32("frame_complete", 32'(exp_q.size()), 32'd0);
            chk32("frame_len", 32'(frame_wr), 32'(tbl[t].n + 2));
            if (tbl[t].stall_at < 0 && wr_cyc.size() > 0)
                chk32("back_to_back", 32'(wr_cyc[wr_cyc.size() - 1] - wr_cyc[0]), 32'(tbl[t].n + 1));
            chk32("seq_after", {24'd0, seq_num}, {24'd0, tbl[t].seq_after});
        end

        // Overflow: 65 words without last drops the record
        do_reset();
        frame_wr = 0;
        words_q.delete();
        for (int i = 0; i < 65; i++) words_q.push_back(32'h0100_0000 + 32'(i));
        start_rec(8'h40);
        send_words(65, 1'b0);
        wait_idle();
        repeat (3) tick();
        chk32("ovf_flag", {31'd0, err_overflow}, 32'd1);
        chk32("ovf_no_abort", {31'd0, err_abort}, 32'd0);
        chk32("ovf_no_writes", 32'(frame_wr), 32'd0);
        chk32("ovf_seq", {24'd0, seq_num}, 32'd0);
        words_q.delete();
        words_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hA5010001);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h7BACBEEE);
        start_rec(8'h01);
        send_words(1, 1'b1);
        wait_idle();
        chk32("ovf_next_frame", 32'(exp_q.size()), 32'd0);

        // Restart mid-record: only the new 1-word record is framed
        frame_wr = 0;
        words_q.delete();
        words_q.push_back(32'hA0);
        words_q.push_back(32'hA1);
        start_rec(8'h34);
        send_words(2, 1'b0);
        exp_q.push_back(32'hA5560101);
        exp_q.push_back(32'h000000FF);
        exp_q.push_back(32'hA55601FE);
        start_rec(8'h56);
        words_q.delete();
        words_q.push_back(32'hFF);
        send_words(1, 1'b1);
        wait_idle();
        chk32("abort_flag", {31'd0, err_abort}, 32'd1);
        chk32("abort_frame", 32'(exp_q.size()), 32'd0);
        chk32("abort_len", 32'(frame_wr), 32'd3);

        // 256 back-to-back 1-word records: sequence wraps
        do_reset();
        for (int i = 0; i < 256; i++) begin
            words_q.delete();
            words_q.push_back(32'h1000_0000 + 32'(i * 7));
            push_model(8'(i) ^ 8'h5A, 1);
            start_rec(8'(i) ^ 8'h5A);
            send_words(1, 1'b1);
            wait_idle();
        end
        chk32("wrap_drain", 32'(exp_q.size()), 32'd0);
        chk32("wrap_seq", {24'd0, seq_num}, {24'd0, exp_seq});

        // Reset during PAYLOAD
        do_reset();
        bus.rec_valid = 1'b1;
        bus.rec_data  = 32'h5555;
        tick();
        bus.rec_valid = 1'b0;
        chk32("stray_abort", {31'd0, err_abort}, 32'd1);
        words_q.delete();
        words_q.push_back(32'h5);
        push_model(8'h21, 1);
        start_rec(8'h21);
        send_words(1, 1'b1);
        wait_idle();
        chk32("pre_reset_seq", {24'd0, seq_num}, 32'd1);
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back(32'hC0DE_0000 + 32'(i));
        push_model(8'h22, 4);
        frame_wr = 0;
        start_rec(8'h22);
        send_words(4, 1'b1);
        begin
            int b;
            b = 0;
            while (frame_wr < 2 && b < 50) begin
                tick();
                b++;
            end
            if (b == 50) chk32("payload_timeout", 32'(b), 32'd0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_seq = 8'd0;
        chk32("mid_rst_fifo_write", {31'd0, bus.fifo_write}, 32'd0);
        chk32("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk32("mid_rst_seq", {24'd0, seq_num}, 32'd0);
        chk32("mid_rst_abort", {31'd0, err_abort}, 32'd0);
        chk32("mid_rst_overflow", {31'd0, err_overflow}, 32'd0);
        words_q.delete();
        words_q.push_back(32'h0BAD_F00D);
        words_q.push_back(32'h1234_5678);
        push_model(8'h23, 2);
        start_rec(8'h23);
        send_words(2, 1'b1);
        wait_idle();
        chk32("post_rst_frame", 32'(exp_q.size()), 32'd0);
        chk32("post_rst_seq", {24'd0, seq_num}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/readback_framer.md
Name: readback_framer

Overview:
- Sits between `control_unit` (producer) and the `readback_buffer` clock-crossing FIFO (write side, `sys_clk` domain).
- Collects a variable-length record of 32-bit readback words into an internal buffer.
- Writes the record into the FIFO as one self-describing frame: header word, payload words, checksum trailer.
- Gives host software record boundaries, sequence numbering and integrity checking.

Parameters:
- `DATA_W`, 32, payload/FIFO word width (fixed at 32 in this design).
- `MAX_WORDS`, 64, maximum payload words per record; must be in 1..255.
- `ADDR_W`, 6, record buffer address width; must satisfy 2**ADDR_W >= MAX_WORDS.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rec_start`  in  1  single-cycle pulse: open a new record.
- `rec_tag`  in  8  record type tag, sampled when `rec_start`=1.
- `rec_valid`  in  1  payload word present on `rec_data`.
- `rec_data`  in  32  payload word.
- `rec_last`  in  1  qualifies `rec_valid`: this is the final word of the record.
- `rec_ready`  out  1  framer accepts payload words this cycle.
- `fifo_full`  in  1  `readback_buffer` write-full flag.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_data`  out  32  FIFO write data.
- `busy`  out  1  state != IDLE.
- `seq_num`  out  8  sequence number of the next frame to be emitted.
- `err_overflow`  out  1  sticky: record exceeded `MAX_WORDS`.
- `err_abort`  out  1  sticky: `rec_start` arrived while collecting, or a stray word arrived in IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; `rec_ready`=0, `fifo_write`=0, `fifo_data`=0, `busy`=0, `seq_num`=0, both error flags=0; buffer pointers=0; any partial or pending frame is discarded.
- A word is accepted when `rec_valid` and `rec_ready` are both 1.
- `fifo_write` = emit state & ~`fifo_full`, combinational. `fifo_data` is valid whenever the framer is in an emit state. A word advances only when `fifo_write`=1, so nothing is lost or duplicated while `fifo_full` is high.
- States:
  - IDLE:
    - `rec_ready`=0.
    - On `rec_start`: latch tag, len=0, chk=0 -> COLLECT.
    - On `rec_valid` without `rec_start`: set `err_abort`, drop the word.
  - COLLECT:
    - `rec_ready`=1.
    - Each accepted word: write it to the buffer at len, len++, chk ^= word.
    - Accepted word with `rec_last`=1 -> HEADER (first header write possible the next cycle).
    - Accepted word when len==`MAX_WORDS` and `rec_last`=0: set `err_overflow`, discard the record -> IDLE.
    - `rec_start` in COLLECT: set `err_abort`, discard the partial record, re-latch tag, len=0, chk=0, stay in COLLECT.
    - If `rec_start` and `rec_valid` are both 1 in the same cycle, the word belongs to the new record.
  - HEADER:
    - `rec_ready`=0.
    - `fifo_data` = {8'hA5, tag, `seq_num`, len[7:0]}.
    - On write -> PAYLOAD, rd_ptr=0.
  - PAYLOAD:
    - `fifo_data` = buf[rd_ptr]. The buffer is a synchronous-read RAM with prefetch, so the next word is ready the cycle after each write: back-to-back writes at one word/cycle when not full.
    - Write with rd_ptr==len-1 -> TRAILER.
  - TRAILER:
    - `fifo_data` = chk ^ header_word.
    - On write: `seq_num` <= `seq_num`+1, wrapping 255->0; -> IDLE.
- Dropped records (overflow) never consume a sequence number.
- A record with `rec_last` on its first word yields len=1. Zero-length records cannot occur.
- `rec_start` during HEADER, PAYLOAD or TRAILER: ignored and sets `err_abort`. `control_unit` must wait for `busy`=0.
- Error flags clear only on reset.
- Frame length on the FIFO is always len+2 words.

Decomposition:
- `readback_framer_pkg`:
  - state enum {IDLE, COLLECT, HEADER, PAYLOAD, TRAILER};
  - HDR_MAGIC=8'hA5;
  - header field offsets.
- One sub-module, `framer_record_buffer`: single-clock, 1W/1R RAM of `MAX_WORDS` x 32 with synchronous read and read-address prefetch.
- The FSM, counters and checksum live in `readback_framer`.

Test Plan:
1. Reset; `rec_start` with tag=0x12; words 0x1, 0x2, 0x4 (last on 0x4); `fifo_full`=0 -> FIFO receives A5120003, 00000001, 00000002, 00000004, A5120004 on 5 consecutive cycles; `seq_num`=1.
2. Same record, with `fifo_full` held high for 10 cycles starting at the 2nd payload write -> `fifo_write`=0 throughout; sequence identical to scenario 1, no gaps or duplicates.
3. `MAX_WORDS`+1=65 words without `rec_last` -> no FIFO writes; `err_overflow`=1; `seq_num` unchanged. A following 1-word record (tag 0x01, word 0xDEADBEEF) emits header A5010001 (seq 00).
4. `rec_start` after 2 words collected, then 1 word 0xFF with last -> `err_abort`=1; only the 1-word frame is emitted, len=1, payload 000000FF.
5. 256 back-to-back 1-word records -> header seq field runs 00..FF; `seq_num` returns to 00.
6. `reset` asserted during PAYLOAD (2nd of 4 words) -> next cycle `fifo_write`=0, state IDLE, `seq_num`=0, flags clear. A fresh record afterwards emits correctly with seq 00.
